// File: rtl/pif_defs.sv
`timescale 1ns/1ps
// Shared definitions for the I2C LED flasher: byte tags, register map, mode and FSM encodings.
package pif_defs;

  localparam int I2C_DATA_BITS = 6;

  localparam logic [1:0] A_ADDR = 2'b00;
  localparam logic [1:0] D_ADDR = 2'b01;

  localparam logic [I2C_DATA_BITS-1:0] REG_ID      = 6'd0;
  localparam logic [I2C_DATA_BITS-1:0] REG_SCRATCH = 6'd1;
  localparam logic [I2C_DATA_BITS-1:0] REG_MODE    = 6'd2;

  typedef enum logic [1:0] {
    MODE_ALT  = 2'd0,
    MODE_SYNC = 2'd1,
    MODE_OFF  = 2'd2,
    MODE_ON   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEVADDR = 3'd1,
    ACK_DEV = 3'd2,
    WRITE   = 3'd3,
    ACK_WR  = 3'd4,
    READ    = 3'd5,
    RACK    = 3'd6
  } i2c_state_e;

  // Unmapped addresses read back as zero.
  function automatic logic [I2C_DATA_BITS-1:0] reg_read(
    input logic [I2C_DATA_BITS-1:0] ptr,
    input logic [I2C_DATA_BITS-1:0] id,
    input logic [I2C_DATA_BITS-1:0] scratch,
    input logic [I2C_DATA_BITS-1:0] mode
  );
    case (ptr)
      REG_ID:      reg_read = id;
      REG_SCRATCH: reg_read = scratch;
      REG_MODE:    reg_read = mode;
      default:     reg_read = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_slave_core.sv
`timescale 1ns/1ps
// Oversampled I2C slave: input synchronizers, START/STOP detection, byte FSM and shifters.
// Hands written bytes to the register file and shifts out a byte supplied by it.
module i2c_slave_core
  import pif_defs::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h41
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  input  logic [7:0] rd_byte,
  output logic       wr_strobe,
  output logic [7:0] wr_byte,
  output logic       rd_req,
  output logic       sda_oe
);

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_state_e state_r, state_nxt;
  logic [3:0] bit_cnt_r, bit_cnt_nxt;
  logic [7:0] shift_r, shift_nxt;
  logic       rw_r, rw_nxt, nack_r, nack_nxt, wr_nxt;
  logic       sda_oe_s, rd_req_s;

  // Idle bus is high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_prev_r <= scl_sync_r[1];
      sda_prev_r <= sda_sync_r[1];
    end
  end

  assign scl_s      = scl_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      rw_r      <= 1'b0;
      nack_r    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_byte   <= 8'd0;
      rd_req    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      shift_r   <= shift_nxt;
      rw_r      <= rw_nxt;
      nack_r    <= nack_nxt;
      wr_strobe <= wr_nxt;
      wr_byte   <= wr_nxt ? shift_nxt : wr_byte;
      rd_req    <= rd_req_s;
      sda_oe    <= sda_oe_s;
    end
  end

  // In READ the bit counter advances on falling edges, so data only changes while SCL is low.
  always_comb begin
    state_nxt   = state_r;
    bit_cnt_nxt = bit_cnt_r;
    shift_nxt   = shift_r;
    rw_nxt      = rw_r;
    nack_nxt    = nack_r;
    wr_nxt      = 1'b0;
    if (stop_s) begin
      state_nxt = IDLE;
    end else if (start_s) begin
      state_nxt   = DEVADDR;
      bit_cnt_nxt = 4'd0;
    end else begin
      case (state_r)
        DEVADDR, WRITE: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_nxt   = {shift_r[6:0], sda_s};
            bit_cnt_nxt = bit_cnt_r + 4'd1;
            wr_nxt      = (state_r == WRITE) && (bit_cnt_r == 4'd7);
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            bit_cnt_nxt = 4'd0;
            if (state_r == WRITE) begin
              state_nxt = ACK_WR;
            end else if (shift_r[7:1] == I2C_ADDR) begin
              state_nxt = ACK_DEV;
              rw_nxt    = shift_r[0];
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = state_r;
          end
        end
        ACK_DEV: begin
          if (scl_fall_s) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = rw_r ? READ : WRITE;
          end else begin
            state_nxt = state_r;
          end
        end
        ACK_WR: begin
          if (scl_fall_s) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = WRITE;
          end else begin
            state_nxt = state_r;
          end
        end
        READ: begin
          if (scl_fall_s && (bit_cnt_r == 4'd7)) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = RACK;
          end else if (scl_fall_s) begin
            bit_cnt_nxt = bit_cnt_r + 4'd1;
          end else begin
            state_nxt = state_r;
          end
        end
        RACK: begin
          if (scl_rise_s) begin
            nack_nxt = sda_s;
          end else if (scl_fall_s) begin
            bit_cnt_nxt = 4'd0;
            state_nxt   = nack_r ? IDLE : READ;
          end else begin
            state_nxt = state_r;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // rd_req stays high until a READ byte begins, which freezes the byte in the register file.
  always_comb begin
    sda_oe_s = 1'b0;
    rd_req_s = 1'b0;
    case (state_r)
      ACK_DEV: begin
        sda_oe_s = 1'b1;
        rd_req_s = rw_r;
      end
      ACK_WR:  sda_oe_s = 1'b1;
      READ:    sda_oe_s = ~rd_byte[3'd7 - bit_cnt_r[2:0]];
      RACK:    rd_req_s = 1'b1;
      default: sda_oe_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/i2c_led_flasher.sv
`timescale 1ns/1ps
// I2C-controlled LED flasher: tagged register file, blink timebase and registered LED decode.
module i2c_led_flasher
  import pif_defs::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h41,
  parameter int          CLK_HZ   = 20000000,
  parameter int          BLINK_HZ = 2,
  parameter logic [5:0] ID_VALUE = 6'h2A
)(
  input  logic CLK,
  input  logic RST,
  input  logic SCL,
  inout  wire  SDA,
  output logic LEDR,
  output logic LEDG
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic                     wr_strobe_s, rd_req_s, sda_oe_s;
  logic [7:0]               wr_byte_s, rd_byte_r;
  logic [I2C_DATA_BITS-1:0] ptr_r, scratch_r, mode_r;
  logic [CW-1:0]            cnt_r;
  logic                     phase_r;

  i2c_slave_core #(.I2C_ADDR(I2C_ADDR)) u_core (
    .clk       (CLK),
    .rst       (RST),
    .scl       (SCL),
    .sda       (SDA),
    .rd_byte   (rd_byte_r),
    .wr_strobe (wr_strobe_s),
    .wr_byte   (wr_byte_s),
    .rd_req    (rd_req_s),
    .sda_oe    (sda_oe_s)
  );

  assign SDA = sda_oe_s ? 1'b0 : 1'bz;

  // ID is not writable; tags 10/11 and unmapped addresses fall through untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_r     <= 6'd0;
      scratch_r <= 6'd0;
      mode_r    <= 6'd0;
      rd_byte_r <= 8'd0;
    end else begin
      if (wr_strobe_s) begin
        case (wr_byte_s[7:6])
          A_ADDR: ptr_r <= wr_byte_s[5:0];
          D_ADDR: begin
            case (ptr_r)
              REG_SCRATCH: scratch_r <= wr_byte_s[5:0];
              REG_MODE:    mode_r    <= wr_byte_s[5:0];
              default:     scratch_r <= scratch_r;
            endcase
          end
          default: ptr_r <= ptr_r;
        endcase
      end
      if (rd_req_s) begin
        rd_byte_r <= {2'b01, reg_read(ptr_r, ID_VALUE, scratch_r, mode_r)};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == HALF_M1) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // Only MODE[1:0] is decoded; upper stored bits have no effect on the LEDs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LEDR <= 1'b0;
      LEDG <= 1'b0;
    end else begin
      case (mode_e'(mode_r[1:0]))
        MODE_ALT:  begin LEDR <= phase_r;  LEDG <= ~phase_r; end
        MODE_SYNC: begin LEDR <= phase_r;  LEDG <= phase_r;  end
        MODE_OFF:  begin LEDR <= 1'b0;     LEDG <= 1'b0;     end
        MODE_ON:   begin LEDR <= 1'b1;     LEDG <= 1'b1;     end
        default:   begin LEDR <= 1'b0;     LEDG <= 1'b0;     end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_led_flasher.sv
`timescale 1ns/1ps
// Directed bench for i2c_led_flasher: bit-banged 400 kHz master against a 20 MHz DUT.
module tb_i2c_led_flasher;

  localparam int HALF = 20;     // 20 MHz / (2 * 500 kHz)
  localparam int Q    = 625;    // quarter of a 2.5 us SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_low = 1'b0;
  logic ledr, ledg;
  wire  sda_bus;

  int n_checks = 0;
  int n_fail   = 0;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  always #25 clk = ~clk;

  i2c_led_flasher #(.CLK_HZ(20000000), .BLINK_HZ(500000)) dut (
    .CLK  (clk),
    .RST  (rst),
    .SCL  (scl),
    .SDA  (sda_bus),
    .LEDR (ledr),
    .LEDG (ledg)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b1; #(2*Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; #(Q);
    scl = 1'b1;     #(Q);
    sda_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_low = ~b[i]; #(Q);
      scl = 1'b1;      #(2*Q);
      scl = 1'b0;      #(Q);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    write_bits(b, 8);
    sda_low = 1'b0; #(Q);
    scl = 1'b1;     #(Q);
    acked = (sda_bus === 1'b0);
    #(Q);
    scl = 1'b0;     #(Q);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d, output logic released);
    for (int i = 7; i >= 0; i--) begin
      sda_low = 1'b0; #(Q);
      scl = 1'b1;     #(Q);
      d[i] = (sda_bus === 1'b1);
      #(Q);
      scl = 1'b0;     #(Q);
    end
    sda_low = master_ack; #(Q);
    scl = 1'b1;           #(Q);
    released = (sda_bus === 1'b1);
    #(Q);
    scl = 1'b0;           #(Q);
    sda_low = 1'b0;
  endtask

  task automatic write_pair(input string tag, input logic [7:0] a, input logic [7:0] d);
    logic ack;
    i2c_start();
    write_byte(8'h82, ack); check({tag, "_ack_dev"}, {7'd0, ack}, 8'h01);
    write_byte(a, ack);     check({tag, "_ack_a"},   {7'd0, ack}, 8'h01);
    write_byte(d, ack);     check({tag, "_ack_d"},   {7'd0, ack}, 8'h01);
    i2c_stop();
  endtask

  task automatic read_reg(input string tag, input logic [5:0] addr, input logic [7:0] exp);
    logic ack, rel;
    logic [7:0] d;
    i2c_start();
    write_byte(8'h82, ack);
    write_byte({2'b00, addr}, ack);
    i2c_stop();
    i2c_start();
    write_byte(8'h83, ack); check({tag, "_ack_rd"}, {7'd0, ack}, 8'h01);
    read_byte(1'b0, d, rel);
    check({tag, "_data"}, d, exp);
    check({tag, "_released"}, {7'd0, rel}, 8'h01);
    i2c_stop();
  endtask

  task automatic check_leds(input string tag, input logic er, input logic eg);
    @(negedge clk);
    check({tag, "_r"}, {7'd0, ledr}, {7'd0, er});
    check({tag, "_g"}, {7'd0, ledg}, {7'd0, eg});
  endtask

  initial begin
    logic ack, r0;

    // Reset values while RST is held
    #60;
    check("rst_ledr", {7'd0, ledr}, 8'h00);
    check("rst_ledg", {7'd0, ledg}, 8'h00);
    check("rst_sda",  {7'd0, sda_bus}, 8'h01);
    #40 rst = 1'b0;

    // Mode 0 alternates and toggles every HALF cycles
    repeat (3) @(negedge clk);
    check("alt_first", {7'd0, ledr}, 8'h00);
    check("alt_diff", {7'd0, ledr ^ ledg}, 8'h01);
    r0 = ledr;
    repeat (HALF) @(negedge clk);
    check("alt_toggle", {7'd0, ledr}, {7'd0, ~r0});
    check("alt_diff2", {7'd0, ledr ^ ledg}, 8'h01);

    // MODE=1: LEDs in step, both phases seen
    write_pair("mode1", 8'h02, 8'h41);
    repeat (2) @(negedge clk);
    r0 = ledr;
    check("sync_eq1", {7'd0, ledr ^ ledg}, 8'h00);
    repeat (HALF) @(negedge clk);
    check("sync_eq2", {7'd0, ledr ^ ledg}, 8'h00);
    check("sync_toggle", {7'd0, ledr}, {7'd0, ~r0});
    read_reg("rb_mode1", 6'd2, 8'h41);

    // Wrong device address: no ACK, nothing written
    i2c_start();
    write_byte(8'h84, ack); check("wrong_addr_nack", {7'd0, ack}, 8'h00);
    write_byte(8'h42, ack); check("wrong_data_nack", {7'd0, ack}, 8'h00);
    i2c_stop();
    read_reg("rb_after_wrong", 6'd2, 8'h41);

    // ID is read-only, scratch is read/write
    write_pair("id_wr", 8'h00, 8'h55);
    read_reg("rb_id", 6'd0, 8'h6A);
    write_pair("scr_wr", 8'h01, 8'h7F);
    read_reg("rb_scratch", 6'd1, 8'h7F);
    read_reg("rb_unmapped", 6'd9, 8'h40);

    // Modes 2 and 3
    write_pair("mode2", 8'h02, 8'h42);
    check_leds("off_a", 1'b0, 1'b0);
    repeat (HALF) @(negedge clk);
    check_leds("off_b", 1'b0, 1'b0);
    write_pair("mode3", 8'h02, 8'h43);
    check_leds("on_a", 1'b1, 1'b1);
    repeat (HALF) @(negedge clk);
    check_leds("on_b", 1'b1, 1'b1);

    // STOP in the middle of a data byte aborts the write
    i2c_start();
    write_byte(8'h82, ack); check("abort_ack_dev", {7'd0, ack}, 8'h01);
    write_byte(8'h02, ack); check("abort_ack_a", {7'd0, ack}, 8'h01);
    write_bits(8'h42, 4);
    i2c_stop();
    check_leds("abort_leds", 1'b1, 1'b1);
    read_reg("rb_after_abort", 6'd2, 8'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #5000000;
    n_fail++;
    $display("FAIL timeout: observed no end of test, required completion within 5 ms");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_led_flasher.md
Name: i2c_led_flasher

Overview:
- I2C slave with a small tagged register file, driving two LEDs (red and green) that blink in a register-selected pattern.
- Top-level control block on the FPGA. A host writes an address byte, then data bytes, to set the LED mode, and reads registers back.
- All logic runs in one system clock domain. SCL/SDA are oversampled; there is no clock stretching.

Parameters:
- I2C_ADDR, 7'h41, 7-bit slave address (8'h82 on the wire with R/W=0).
- CLK_HZ, 20000000, system clock frequency.
- BLINK_HZ, 2, LED toggle frequency. Half-period = CLK_HZ/(2*BLINK_HZ) cycles.
- ID_VALUE, 6'h2A, read-only contents of register 0.

Ports:
- CLK  in  1  system clock, 20 MHz.
- RST  in  1  asynchronous, active-high reset.
- SCL  in  1  I2C clock, externally pulled up.
- SDA  inout  1  I2C data, open-drain: the block only drives 0 or Z.
- LEDR  out  1  red LED, active-high.
- LEDG  out  1  green LED, active-high.

Behaviour:
- Reset: one clock; RST is asynchronous and active-high.
  - All state clears: FSM IDLE, addr pointer 0, MODE 0, blink counter 0, phase 0.
  - SDA released (Z); LEDR=0, LEDG=0.
- Input sync: SCL and SDA each pass through 2-flop synchronizers plus one history flop.
  - START: SDA falls while SCL=1.
  - STOP: SDA rises while SCL=1.
  - Bits are sampled on the SCL rising edge.
- FSM states: IDLE, DEVADDR, ACK_DEV, WRITE, ACK_WR, READ, RACK.
  - IDLE -> DEVADDR on START.
  - DEVADDR shifts 8 bits, MSB first. On match of bits[7:1] with I2C_ADDR: drive SDA low from the SCL falling edge after bit 0 until the next SCL falling edge (ACK), then go to WRITE (R/W=0) or READ (R/W=1). On mismatch: no ACK, back to IDLE.
  - WRITE shifts 8 bits, ACKs each byte (ACK_WR), then returns to WRITE.
  - READ shifts out a byte MSB first; each bit is driven on the SCL falling edge.
  - RACK samples the master's ACK/NACK. ACK -> next READ byte; NACK -> IDLE.
  - A STOP from any state -> IDLE and releases SDA. A repeated START from any state -> DEVADDR.
- Written byte format: bits[7:6] tag, bits[5:0] payload.
  - Tag 2'b00 (A_ADDR): load the address pointer with the payload.
  - Tag 2'b01 (D_ADDR): write the payload to reg[pointer].
  - Tags 2'b10 and 2'b11: ignored but still ACKed.
  - The pointer never auto-increments.
- Registers (6-bit, 64-entry map):
  - 0 ID, read-only, ID_VALUE; writes are ignored.
  - 1 SCRATCH, read/write.
  - 2 MODE, read/write: 0 alternate, 1 sync, 2 off, 3 both on. Values >3 are stored; only bits[1:0] are decoded.
  - All other addresses read 0; writes to them are ignored.
- Read byte = {2'b01, reg[pointer]}. The byte is latched when the READ byte starts, so a mid-read register change does not corrupt it.
- Register writes take effect on the clock after the 8th bit is sampled, before the ACK.
- Blink timing: the counter counts 0..HALF-1, then wraps and toggles phase.
- LED decode (registered outputs, one cycle latency from MODE/phase):
  - MODE 0: LEDR=phase, LEDG=~phase.
  - MODE 1: LEDR=LEDG=phase.
  - MODE 2: both 0.
  - MODE 3: both 1.
- Reset mid-transaction: SDA is released immediately and the bus is ignored until the next START.

Decomposition:
- Shared package (pif_defs):
  - I2C_DATA_BITS=6.
  - Tag constants A_ADDR=2'b00, D_ADDR=2'b01.
  - Register indices REG_ID=0, REG_SCRATCH=1, REG_MODE=2.
  - MODE encodings.
- One sub-module i2c_slave_core: synchronizers, START/STOP detection, FSM, shifters. Outputs wr_strobe/wr_byte and rd_req, takes rd_byte, and drives sda_oe.
- The top block holds the register file and the blink/LED logic.

Test Plan:
- Reset: RST=1 for 100 ns -> LEDR=0, LEDG=0, SDA=Z. After release, MODE=0 and the LEDs alternate (LEDR≠LEDG) every HALF cycles.
- Write sequence START, 0x82, 0x02, 0x41, STOP at 400 kHz -> three ACKs, MODE=1, LEDR==LEDG thereafter.
- Read-back: START, 0x82, 0x02, STOP; then START, 0x83, read one byte with NACK, STOP -> byte 0x41 returned, SDA released after the byte.
- Wrong address: START, 0x84, ... -> no ACK (SDA stays high on the 9th clock), registers unchanged.
- ID and scratch:
  - Write 0x00, 0x55 (address 0, data 0x15) -> ID unchanged; reading register 0 returns 0x6A.
  - Write 0x01, 0x7F, then read -> 0x7F.
- Modes 2 and 3: write 0x02, 0x42 -> both LEDs 0 constantly. Write 0x02, 0x43 -> both LEDs 1. A STOP mid-byte aborts without a register write.
